// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: default polynomial, frame-checker FSM states
// and the MSB-first byte-step function used by the crc8_step generator.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2,
        DROP    = 2'd3
    } crc8_state_e;

    // One byte of CRC-8: fold the byte in, then eight MSB-first shifts,
    // XORing the polynomial whenever a one falls off the top.
    // No reflection and no final XOR.
    function automatic logic [7:0] crc8_byte_step(input logic [7:0] crc,
                                                  input logic [7:0] data,
                                                  input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_step.sv
// Combinational single-byte CRC-8 update, parameterised by polynomial.
module crc8_step
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    // Pure byte-step; all sequencing lives in the frame checker.
    always_comb begin
        crc_o = crc8_byte_step(crc_i, data_i, POLYNOMIAL);
    end

endmodule

// File: rtl/crc8_frame_checker.sv
// CRC-8 frame checker: forwards payload bytes, computes a running CRC-8,
// compares it with the trailing CRC byte and flags over-length frames.
// Optional build macro CRC8_FRAME_CHECKER_STATS_EN adds saturating
// frame and error counters (frame_cnt_o, err_cnt_o).
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter logic [7:0]  POLYNOMIAL = CRC8_POLY_DEFAULT,
    parameter logic [7:0]  INIT       = 8'h00,
    parameter int unsigned MAX_LEN    = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic [7:0] crc_o,
    output logic       frame_done_o,
    output logic       crc_ok_o,
    output logic       len_err_o
`ifdef CRC8_FRAME_CHECKER_STATS_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int unsigned    LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    crc8_state_e      state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             discard_q, discard_d;
    logic [7:0]       data_q, data_d;
    logic             dvalid_q, dvalid_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             lerr_q, lerr_d;

    logic [7:0]       step_in;
    logic [7:0]       step_out;

    // The first byte of a frame is stepped from the seed, later ones from the running CRC.
    always_comb begin
        step_in = (state_q == IDLE) ? INIT : crc_q;
    end

    crc8_step #(
        .POLYNOMIAL(POLYNOMIAL)
    ) u_step (
        .crc_i (step_in),
        .data_i(data_i),
        .crc_o (step_out)
    );

    // Frame FSM: next-state, CRC/length update, forwarding and result decode.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        discard_d = discard_q;
        data_d    = data_q;
        dvalid_d  = 1'b0;
        done_d    = 1'b0;
        ok_d      = ok_q;
        lerr_d    = lerr_q;

        if (data_valid_i) begin
            unique case (state_q)
                IDLE: begin
                    crc_d    = step_out;
                    len_d    = LEN_W'(1);
                    data_d   = data_i;
                    dvalid_d = 1'b1;
                    state_d  = data_last_i ? CRC : PAYLOAD;
                end
                PAYLOAD: begin
                    if (len_q < MAX_LEN_C) begin
                        crc_d    = step_out;
                        len_d    = len_q + LEN_W'(1);
                        data_d   = data_i;
                        dvalid_d = 1'b1;
                        if (data_last_i) state_d = CRC;
                    end else begin
                        // Over-length: report now, then swallow the rest of the frame.
                        done_d  = 1'b1;
                        ok_d    = 1'b0;
                        lerr_d  = 1'b1;
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (data_last_i) begin
                        discard_d = 1'b1;
                        state_d   = CRC;
                    end
                end
                CRC: begin
                    if (!discard_q) begin
                        done_d = 1'b1;
                        ok_d   = (data_i == crc_q);
                        lerr_d = 1'b0;
                    end
                    crc_d     = INIT;
                    len_d     = '0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            len_q     <= '0;
            discard_q <= 1'b0;
            data_q    <= '0;
            dvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            discard_q <= discard_d;
            data_q    <= data_d;
            dvalid_q  <= dvalid_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            lerr_q    <= lerr_d;
        end
    end

    always_comb begin
        data_o       = data_q;
        data_valid_o = dvalid_q;
        crc_o        = crc_q;
        frame_done_o = done_q;
        crc_ok_o     = ok_q;
        len_err_o    = lerr_q;
    end

`ifdef CRC8_FRAME_CHECKER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters, advanced in step with the registered frame_done_o pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (done_d) begin
            if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (!ok_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    always_comb begin
        frame_cnt_o = frame_cnt_q;
        err_cnt_o   = err_cnt_q;
    end
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker: default instance (MAX_LEN=255)
// plus a MAX_LEN=4 instance sharing the same input stimulus.
module tb_crc8_frame_checker;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       dvalid;
    logic       dlast;

    logic [7:0] dout,  dout4;
    logic       dv,    dv4;
    logic [7:0] crc,   crc4;
    logic       done,  done4;
    logic       ok,    ok4;
    logic       lerr,  lerr4;
`ifdef CRC8_FRAME_CHECKER_STATS_EN
    logic [15:0] fcnt, ecnt, fcnt4, ecnt4;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] fwd[$];
    int         done_cnt  = 0;
    int         fwd4_cnt  = 0;
    int         done4_cnt = 0;

    int base_f, base_d, base_f4, base_d4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    crc8_frame_checker dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .data_i      (din),
        .data_valid_i(dvalid),
        .data_last_i (dlast),
        .data_o      (dout),
        .data_valid_o(dv),
        .crc_o       (crc),
        .frame_done_o(done),
        .crc_ok_o    (ok),
        .len_err_o   (lerr)
`ifdef CRC8_FRAME_CHECKER_STATS_EN
        ,
        .frame_cnt_o (fcnt),
        .err_cnt_o   (ecnt)
`endif
    );

    crc8_frame_checker #(.MAX_LEN(4)) dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .data_i      (din),
        .data_valid_i(dvalid),
        .data_last_i (dlast),
        .data_o      (dout4),
        .data_valid_o(dv4),
        .crc_o       (crc4),
        .frame_done_o(done4),
        .crc_ok_o    (ok4),
        .len_err_o   (lerr4)
`ifdef CRC8_FRAME_CHECKER_STATS_EN
        ,
        .frame_cnt_o (fcnt4),
        .err_cnt_o   (ecnt4)
`endif
    );

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dv)    fwd.push_back(dout);
        if (done)  done_cnt++;
        if (dv4)   fwd4_cnt++;
        if (done4) done4_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic l);
        din    = b;
        dvalid = 1'b1;
        dlast  = l;
        @(negedge clk);
        dvalid = 1'b0;
        dlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        dvalid = 1'b0;
        dlast  = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_check_string(input logic [7:0] crcb, input bit gaps);
        for (int i = 0; i < 9; i++) begin
            drive(8'h31 + 8'(i), (i == 8));
            if (gaps) idle(int'($urandom_range(0, 5)));
        end
        chk("crc_o_123456789", {8'h00, crc}, 16'h00F4);
        drive(crcb, 1'b0);
        idle(2);
    endtask

    task automatic check_fwd_string(input string tag);
        chk({tag, "_fwd_count"}, 16'(fwd.size() - base_f), 16'd9);
        for (int i = 0; i < 9; i++) begin
            if (base_f + i < fwd.size())
                chk({tag, "_fwd_byte"}, {8'h00, fwd[base_f + i]}, 16'h0031 + 16'(i));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        din    = 8'h00;
        dvalid = 1'b0;
        dlast  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_crc_o",   {8'h00, crc},  16'h0000);
        chk("rst_data_o",  {8'h00, dout}, 16'h0000);
        chk("rst_dvalid",  16'(dv),       16'd0);
        chk("rst_done",    16'(done),     16'd0);
        chk("rst_ok",      16'(ok),       16'd0);
        chk("rst_lerr",    16'(lerr),     16'd0);
        rst_n = 1'b1;
        idle(2);

        // Good check string
        base_f = fwd.size(); base_d = done_cnt;
        send_check_string(8'hF4, 1'b0);
        check_fwd_string("good");
        chk("good_done_cnt", 16'(done_cnt - base_d), 16'd1);
        chk("good_ok",       16'(ok),   16'd1);
        chk("good_lerr",     16'(lerr), 16'd0);
        chk("good_crc_reload", {8'h00, crc}, 16'h0000);

        // Bad CRC byte
        base_f = fwd.size(); base_d = done_cnt;
        send_check_string(8'hF5, 1'b0);
        chk("bad_done_cnt", 16'(done_cnt - base_d), 16'd1);
        chk("bad_ok",       16'(ok), 16'd0);

        // Single-byte frame
        base_d = done_cnt;
        drive(8'h01, 1'b1);
        chk("single_crc_o", {8'h00, crc}, 16'h0007);
        drive(8'h07, 1'b0);
        idle(2);
        chk("single_done_cnt", 16'(done_cnt - base_d), 16'd1);
        chk("single_ok",       16'(ok), 16'd1);
`ifdef CRC8_FRAME_CHECKER_STATS_EN
        chk("stats_frame_cnt", fcnt, 16'd3);
        chk("stats_err_cnt",   ecnt, 16'd1);
`endif

        // Check string with random idle gaps
        base_f = fwd.size(); base_d = done_cnt;
        send_check_string(8'hF4, 1'b1);
        check_fwd_string("gaps");
        chk("gaps_done_cnt", 16'(done_cnt - base_d), 16'd1);
        chk("gaps_ok",       16'(ok), 16'd1);

        // Reset mid-frame
        base_d = done_cnt;
        drive(8'hAA, 1'b0);
        drive(8'hBB, 1'b0);
        drive(8'hCC, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("midrst_no_done", 16'(done_cnt - base_d), 16'd0);
        chk("midrst_crc_o",   {8'h00, crc}, 16'h0000);
        drive(8'h01, 1'b1);
        drive(8'h07, 1'b0);
        idle(2);
        chk("midrst_next_done", 16'(done_cnt - base_d), 16'd1);
        chk("midrst_next_ok",   16'(ok), 16'd1);

        // Over-length frame on the MAX_LEN=4 instance
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        base_f4 = fwd4_cnt; base_d4 = done4_cnt;
        for (int i = 0; i < 4; i++) drive(8'hA0 + 8'(i), 1'b0);
        chk("ovf_no_early_done", 16'(done4_cnt - base_d4), 16'd0);
        drive(8'hA4, 1'b0);
        chk("ovf_done_pulse", 16'(done4), 16'd1);
        chk("ovf_lerr",       16'(lerr4), 16'd1);
        chk("ovf_ok",         16'(ok4),   16'd0);
        drive(8'hA5, 1'b0);
        drive(8'hA6, 1'b1);
        drive(8'h55, 1'b0);
        idle(2);
        chk("ovf_fwd_count", 16'(fwd4_cnt - base_f4), 16'd4);
        chk("ovf_done_cnt",  16'(done4_cnt - base_d4), 16'd1);
        chk("ovf_lerr_held", 16'(lerr4), 16'd1);

        // Exactly MAX_LEN bytes with last on the final one is a valid frame
        base_f4 = fwd4_cnt; base_d4 = done4_cnt;
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h01, 1'b1);
        chk("maxlen_crc_o", {8'h00, crc4}, 16'h0007);
        drive(8'h07, 1'b0);
        idle(2);
        chk("maxlen_fwd_count", 16'(fwd4_cnt - base_f4), 16'd4);
        chk("maxlen_done_cnt",  16'(done4_cnt - base_d4), 16'd1);
        chk("maxlen_ok",        16'(ok4),   16'd1);
        chk("maxlen_lerr",      16'(lerr4), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
